imem_loader: RTL and testbench

Streaming program loader that writes 16-bit instruction words into the instruction memory read by the fetch stage, while it holds the pipeline. It sits beside the core at top level, is fed by a host/testbench over a valid/ready stream, and drives the instruction memory write port. After the last word it verifies a trailing checksum, then releases the processor.

---
 rtl/bwzz_pkg.sv | 15 +
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bwzz_pkg.sv
// Shared types and widths for the instruction-memory loader.
// Imported by the loader and anything that sizes the imem port.
package bwzz_pkg;

  localparam int INST_W      = 16;
  localparam int IMEM_ADDR_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams instruction words into imem while holding the core,
// then checks a trailing checksum and releases the core.
module imem_loader
  import bwzz_pkg::*;
#(
  parameter int ADDR_W        = IMEM_ADDR_W,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [INST_W-1:0] sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              hs;
  logic [INST_W-1:0] sum_nxt;
  logic [INST_W-1:0] chk_sum;
  logic [ADDR_W:0]   cnt_inc;

  // Ready comes only from the state register, never from in_valid.
  assign accept  = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign hs      = in_valid && accept;
  assign sum_nxt = sum_q + in_data;
  assign chk_sum = sum_q + in_data;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (load_start) begin
          base_d  = load_base;
          len_d   = load_len;
          sum_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          state_d = (load_len == '0) ? ST_CHECK : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = base_q + cnt_q[ADDR_W-1:0];
          wdata_d = in_data;
          sum_d   = sum_nxt;
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hs) begin
          if (chk_sum == '0) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= HOLD_AT_RESET;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready      = accept;
  assign busy          = accept;
  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign error         = err_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [19:0] load_base;
  logic [20:0] load_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        imem_we;
  logic [19:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [20:0] words_written;

  int n_chk;
  int n_err;
  int done_cnt;
  logic [19:0] wa[$];
  logic [15:0] wd[$];

  imem_loader #(.ADDR_W(20), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .load_base(load_base),
    .load_len(load_len),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .done(done),
    .error(error),
    .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [19:0] b,
                       input logic [20:0] l);
    wa.delete();
    wd.delete();
    done_cnt   = 0;
    load_start = 1'b1;
    load_base  = b;
    load_len   = l;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    done_cnt   = 0;
    reset      = 1'b1;
    load_start = 1'b0;
    load_base  = '0;
    load_len   = '0;
    in_valid   = 1'b0;
    in_data    = '0;

    #3 reset = 1'b0;
    #1;
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_ww", 32'(words_written), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // nominal load
    start(20'h00010, 21'd3);
    chk("nom_busy", 32'(busy), 32'd1);
    chk("nom_hold", 32'(cpu_hold), 32'd1);
    send(16'h1234);
    send(16'h5678);
    send(16'h9ABC);
    chk("nom_rdy_chk", 32'(in_ready), 32'd1);
    send(16'hFC98);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_hold0", 32'(cpu_hold), 32'd0);
    idle(1);
    chk("nom_done0", 32'(done), 32'd0);
    idle(2);
    chk("nom_ww", 32'(words_written), 32'd3);
    chk("nom_dcnt", 32'(done_cnt), 32'd1);
    chk("nom_nw", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      chk("nom_a0", 32'(wa[0]), 32'h00010);
      chk("nom_d0", 32'(wd[0]), 32'h1234);
      chk("nom_a1", 32'(wa[1]), 32'h00011);
      chk("nom_d1", 32'(wd[1]), 32'h5678);
      chk("nom_a2", 32'(wa[2]), 32'h00012);
      chk("nom_d2", 32'(wd[2]), 32'h9ABC);
    end

    // bad checksum
    start(20'h00010, 21'd3);
    send(16'h1234);
    send(16'h5678);
    send(16'h9ABC);
    send(16'h0000);
    idle(3);
    chk("bad_err", 32'(error), 32'd1);
    chk("bad_hold", 32'(cpu_hold), 32'd1);
    chk("bad_rdy", 32'(in_ready), 32'd0);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_dcnt", 32'(done_cnt), 32'd0);

    // wrap, started from ERR
    start(20'hFFFFF, 21'd2);
    chk("wrap_errclr", 32'(error), 32'd0);
    send(16'h0001);
    send(16'h0002);
    send(16'hFFFD);
    idle(2);
    chk("wrap_dcnt", 32'(done_cnt), 32'd1);
    chk("wrap_nw", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("wrap_a0", 32'(wa[0]), 32'hFFFFF);
      chk("wrap_a1", 32'(wa[1]), 32'h00000);
      chk("wrap_d1", 32'(wd[1]), 32'h0002);
    end

    // zero length
    start(20'h00300, 21'd0);
    chk("zl_rdy", 32'(in_ready), 32'd1);
    send(16'h0000);
    chk("zl_done", 32'(done), 32'd1);
    idle(2);
    chk("zl_nw", 32'(wa.size()), 32'd0);
    chk("zl_ww", 32'(words_written), 32'd0);

    // stalls plus ignored start
    start(20'h00100, 21'd2);
    idle(3);
    send(16'h1111);
    load_start = 1'b1;
    load_base  = 20'h00555;
    load_len   = 21'd7;
    @(negedge clk);
    load_start = 1'b0;
    idle(3);
    chk("st_busy", 32'(busy), 32'd1);
    chk("st_ww1", 32'(words_written), 32'd1);
    send(16'h2222);
    idle(3);
    send(16'hCCCD);
    idle(2);
    chk("st_dcnt", 32'(done_cnt), 32'd1);
    chk("st_ww", 32'(words_written), 32'd2);
    chk("st_nw", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("st_a0", 32'(wa[0]), 32'h00100);
      chk("st_a1", 32'(wa[1]), 32'h00101);
      chk("st_d1", 32'(wd[1]), 32'h2222);
    end

    // reset mid-load
    start(20'h00200, 21'd3);
    send(16'h4321);
    #2 reset = 1'b0;
    #1;
    chk("mr_hold", 32'(cpu_hold), 32'd1);
    chk("mr_we", 32'(imem_we), 32'd0);
    chk("mr_ww", 32'(words_written), 32'd0);
    chk("mr_rdy", 32'(in_ready), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    start(20'h00040, 21'd1);
    send(16'h00AA);
    send(16'hFF56);
    chk("mr_done", 32'(done), 32'd1);
    idle(2);
    chk("mr_nw", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("mr_a0", 32'(wa[0]), 32'h00040);
      chk("mr_d0", 32'(wd[0]), 32'h00AA);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
